// File: rtl/updown_bounce_counter_pkg.sv
// ============================================================================
// updown_bounce_counter_pkg : shared mode and direction encodings
// Rev 1.0
// ============================================================================
`default_nettype none

package updown_bounce_counter_pkg;

  localparam logic [1:0] MODE_UP_WRAP = 2'b00;
  localparam logic [1:0] MODE_DN_WRAP = 2'b01;
  localparam logic [1:0] MODE_BOUNCE  = 2'b10;
  localparam logic [1:0] MODE_HOLD    = 2'b11;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage

`default_nettype wire

// File: rtl/updown_next_calc.sv
// ============================================================================
// updown_next_calc : combinational step function for the bounded up/down counter
// Rev 1.0
// ============================================================================
`default_nettype none

module updown_next_calc #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] count,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] nxt_count,
  output logic             nxt_dir,
  output logic             nxt_turn,
  output logic             nxt_err
);

  import updown_bounce_counter_pkg::*;

  logic w_bad_bounds;
  logic w_single;
  logic w_out_of_range;
  logic w_at_lo;
  logic w_at_hi;

  assign w_bad_bounds   = (lo > hi);
  assign w_single       = (lo == hi);
  assign w_out_of_range = (count < lo) || (count > hi);
  assign w_at_lo        = (count == lo);
  assign w_at_hi        = (count == hi);

  // +1/-1 are only taken strictly inside [lo,hi], so they can never carry or borrow.
  always_comb begin
    nxt_count = count;
    nxt_dir   = dir;
    nxt_turn  = 1'b0;
    nxt_err   = w_bad_bounds;
    if (w_bad_bounds) begin
      nxt_count = count;
    end else if (w_single) begin
      nxt_count = lo;
    end else if (w_out_of_range) begin
      nxt_count = lo;
      nxt_dir   = DIR_UP;
      nxt_turn  = 1'b1;
    end else begin
      case (mode)
        MODE_UP_WRAP: begin
          nxt_dir = DIR_UP;
          if (w_at_hi) begin
            nxt_count = lo;
            nxt_turn  = 1'b1;
          end else begin
            nxt_count = count + 1'b1;
          end
        end
        MODE_DN_WRAP: begin
          nxt_dir = DIR_DN;
          if (w_at_lo) begin
            nxt_count = hi;
            nxt_turn  = 1'b1;
          end else begin
            nxt_count = count - 1'b1;
          end
        end
        MODE_BOUNCE: begin
          if (dir == DIR_UP) begin
            if (w_at_hi) begin
              nxt_count = count - 1'b1;
              nxt_dir   = DIR_DN;
              nxt_turn  = 1'b1;
            end else begin
              nxt_count = count + 1'b1;
            end
          end else begin
            if (w_at_lo) begin
              nxt_count = count + 1'b1;
              nxt_dir   = DIR_UP;
              nxt_turn  = 1'b1;
            end else begin
              nxt_count = count - 1'b1;
            end
          end
        end
        default: begin
          nxt_count = count;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/updown_bounce_counter.sv
// ============================================================================
// updown_bounce_counter : bounded up/down/bounce counter with load and status flags
// Rev 1.0
// ============================================================================
`default_nettype none

module updown_bounce_counter #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter logic             RST_DIR = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             load_dir,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             turn,
  output logic             bnd_err
);

  import updown_bounce_counter_pkg::*;

  logic [WIDTH-1:0] r_count;
  logic             r_dir;
  logic             r_turn;
  logic             r_err;

  logic [WIDTH-1:0] w_nxt_count;
  logic             w_nxt_dir;
  logic             w_nxt_turn;
  logic             w_nxt_err;
  logic             w_step;

  assign w_step = en && (mode != MODE_HOLD);

  updown_next_calc #(
    .WIDTH (WIDTH)
  ) u_next_calc (
    .count     (r_count),
    .dir       (r_dir),
    .mode      (mode),
    .lo        (lo),
    .hi        (hi),
    .nxt_count (w_nxt_count),
    .nxt_dir   (w_nxt_dir),
    .nxt_turn  (w_nxt_turn),
    .nxt_err   (w_nxt_err)
  );

  // Invalid bounds freeze count/dir even on a load cycle; only bnd_err moves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= RST_VAL;
      r_dir   <= RST_DIR;
      r_turn  <= 1'b0;
      r_err   <= 1'b0;
    end else if (load) begin
      r_turn <= 1'b0;
      r_err  <= w_nxt_err;
      if (!w_nxt_err) begin
        r_count <= load_val;
        r_dir   <= load_dir;
      end
    end else if (w_step) begin
      r_count <= w_nxt_count;
      r_dir   <= w_nxt_dir;
      r_turn  <= w_nxt_turn;
      r_err   <= w_nxt_err;
    end else begin
      r_turn <= 1'b0;
    end
  end

  assign count   = r_count;
  assign dir     = r_dir;
  assign turn    = r_turn;
  assign bnd_err = r_err;

endmodule

`default_nettype wire

// File: tb/tb_updown_bounce_counter.sv
// ============================================================================
// tb_updown_bounce_counter : directed vector bench for 4-bit and 8-bit counters
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_updown_bounce_counter;

  localparam logic [1:0] U = 2'b00;
  localparam logic [1:0] D = 2'b01;
  localparam logic [1:0] B = 2'b10;
  localparam logic [1:0] H = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, load, load_dir;
  logic [1:0] mode;
  logic [3:0] lo, hi, load_val;
  logic [3:0] count;
  logic       dir, turn, bnd_err;

  logic       en8, load8, load_dir8;
  logic [1:0] mode8;
  logic [7:0] lo8, hi8, load_val8;
  logic [7:0] count8;
  logic       dir8, turn8, bnd_err8;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  updown_bounce_counter #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .lo(lo), .hi(hi),
    .load(load), .load_val(load_val), .load_dir(load_dir),
    .count(count), .dir(dir), .turn(turn), .bnd_err(bnd_err)
  );

  updown_bounce_counter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .en(en8), .mode(mode8), .lo(lo8), .hi(hi8),
    .load(load8), .load_val(load_val8), .load_dir(load_dir8),
    .count(count8), .dir(dir8), .turn(turn8), .bnd_err(bnd_err8)
  );

  typedef struct {
    logic       load;
    logic [3:0] load_val;
    logic       load_dir;
    logic       en;
    logic [1:0] mode;
    logic [3:0] lo;
    logic [3:0] hi;
    logic [3:0] e_count;
    logic       e_dir;
    logic       e_turn;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic ld, input logic [3:0] lv, input logic ldir,
                     input logic e, input logic [1:0] m, input logic [3:0] l,
                     input logic [3:0] h, input logic [3:0] ec, input logic ed,
                     input logic et, input logic ee);
    vec_t v;
    v.load = ld; v.load_val = lv; v.load_dir = ldir; v.en = e; v.mode = m;
    v.lo = l; v.hi = h; v.e_count = ec; v.e_dir = ed; v.e_turn = et; v.e_err = ee;
    vecs.push_back(v);
  endtask

  // Compared values are packed as {count, dir, turn, bnd_err}.
  task automatic check(input string nm, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got {count,dir,turn,err}=%h, expected %h", nm, idx, act, exp);
  endtask

  function automatic logic [15:0] pk4(input logic [3:0] c, input logic d, input logic t,
                                      input logic e);
    return {9'd0, c, d, t, e};
  endfunction

  function automatic logic [15:0] pk8(input logic [7:0] c, input logic d, input logic t,
                                      input logic e);
    return {5'd0, c, d, t, e};
  endfunction

  initial begin
    // test 2: wrap modes with narrow bounds
    add(1, 3, 1, 0, U, 3, 6,  3, 1, 0, 0);
    add(0, 0, 0, 1, U, 3, 6,  4, 1, 0, 0);
    add(0, 0, 0, 1, U, 3, 6,  5, 1, 0, 0);
    add(0, 0, 0, 1, U, 3, 6,  6, 1, 0, 0);
    add(0, 0, 0, 1, U, 3, 6,  3, 1, 1, 0);
    add(0, 0, 0, 1, D, 3, 6,  6, 0, 1, 0);
    add(0, 0, 0, 1, D, 3, 6,  5, 0, 0, 0);
    add(0, 0, 0, 1, D, 3, 6,  4, 0, 0, 0);
    add(0, 0, 0, 1, D, 3, 6,  3, 0, 0, 0);
    add(0, 0, 0, 1, D, 3, 6,  6, 0, 1, 0);
    // test 3: out-of-range resync
    add(1, 9, 1, 0, U, 3, 6,  9, 1, 0, 0);
    add(0, 0, 0, 1, U, 2, 5,  2, 1, 1, 0);
    add(0, 0, 0, 1, U, 2, 5,  3, 1, 0, 0);
    add(0, 0, 0, 1, U, 2, 5,  4, 1, 0, 0);
    add(0, 0, 0, 1, U, 2, 5,  5, 1, 0, 0);
    // test 4: inverted bounds
    add(0, 0, 0, 1, U, 8, 4,  5, 1, 0, 1);
    add(0, 0, 0, 0, U, 8, 4,  5, 1, 0, 1);
    add(0, 0, 0, 1, U, 8, 12, 8, 1, 1, 0);
    add(0, 0, 0, 1, U, 8, 12, 9, 1, 0, 0);
    // test 5: load beats en, hold, bounce turns
    add(1, 11, 0, 1, B, 8, 12, 11, 0, 0, 0);
    add(0, 0, 0, 1, B, 8, 12, 10, 0, 0, 0);
    add(0, 0, 0, 1, H, 8, 12, 10, 0, 0, 0);
    add(0, 0, 0, 0, B, 8, 12, 10, 0, 0, 0);
    add(0, 0, 0, 1, B, 8, 12,  9, 0, 0, 0);
    add(0, 0, 0, 1, B, 8, 12,  8, 0, 0, 0);
    add(0, 0, 0, 1, B, 8, 12,  9, 1, 1, 0);
    add(0, 0, 0, 1, B, 8, 12, 10, 1, 0, 0);
    add(0, 0, 0, 1, B, 8, 12, 11, 1, 0, 0);
    add(0, 0, 0, 1, B, 8, 12, 12, 1, 0, 0);
    add(0, 0, 0, 1, B, 8, 12, 11, 0, 1, 0);
    add(0, 0, 0, 0, B, 8, 12, 11, 0, 0, 0);
    // degenerate range lo==hi keeps dir
    add(0, 0, 0, 1, B, 4, 4,   4, 0, 0, 0);
    add(0, 0, 0, 1, U, 4, 4,   4, 0, 0, 0);
    add(0, 0, 0, 1, U, 0, 15,  5, 1, 0, 0);
    // full-range wrap, then mode change keeps dir
    add(1, 15, 1, 0, U, 0, 15, 15, 1, 0, 0);
    add(0, 0, 0, 1, U, 0, 15,  0, 1, 1, 0);
    add(0, 0, 0, 1, D, 0, 15, 15, 0, 1, 0);
    add(0, 0, 0, 1, D, 0, 15, 14, 0, 0, 0);
    add(0, 0, 0, 1, B, 0, 15, 13, 0, 0, 0);

    rst = 1'b1; en = 1'b0; load = 1'b0; load_dir = 1'b0; load_val = '0;
    mode = B; lo = 4'd0; hi = 4'd15;
    en8 = 1'b0; load8 = 1'b0; load_dir8 = 1'b0; load_val8 = '0;
    mode8 = B; lo8 = 8'd0; hi8 = 8'd255;

    repeat (2) @(posedge clk);
    #1;
    check("reset4", 0, pk4(count, dir, turn, bnd_err), pk4(4'd0, 1'b1, 1'b0, 1'b0));
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;

    // test 1: full-range bounce 0..15..0..1
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk); #1;
      check("bounce4_up", i, pk4(count, dir, turn, bnd_err), pk4(4'(i), 1'b1, 1'b0, 1'b0));
    end
    @(posedge clk); #1;
    check("bounce4_top", 0, pk4(count, dir, turn, bnd_err), pk4(4'd14, 1'b0, 1'b1, 1'b0));
    for (int i = 13; i >= 0; i--) begin
      @(posedge clk); #1;
      check("bounce4_dn", i, pk4(count, dir, turn, bnd_err), pk4(4'(i), 1'b0, 1'b0, 1'b0));
    end
    @(posedge clk); #1;
    check("bounce4_bot", 0, pk4(count, dir, turn, bnd_err), pk4(4'd1, 1'b1, 1'b1, 1'b0));

    // tests 2-5: table
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      load = vecs[i].load; load_val = vecs[i].load_val; load_dir = vecs[i].load_dir;
      en = vecs[i].en; mode = vecs[i].mode; lo = vecs[i].lo; hi = vecs[i].hi;
      @(posedge clk); #1;
      check("vec", i, pk4(count, dir, turn, bnd_err),
            pk4(vecs[i].e_count, vecs[i].e_dir, vecs[i].e_turn, vecs[i].e_err));
    end

    // test 6: async reset between edges
    @(negedge clk);
    load = 1'b0; en = 1'b1; mode = B; lo = 4'd0; hi = 4'd15;
    @(posedge clk); #1;
    check("pre_rst", 0, pk4(count, dir, turn, bnd_err), pk4(4'd12, 1'b0, 1'b0, 1'b0));
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", 0, pk4(count, dir, turn, bnd_err), pk4(4'd0, 1'b1, 1'b0, 1'b0));
    @(posedge clk); #1;
    check("rst_held", 0, pk4(count, dir, turn, bnd_err), pk4(4'd0, 1'b1, 1'b0, 1'b0));
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    en8 = 1'b1;
    #1;
    check("reset8", 0, pk8(count8, dir8, turn8, bnd_err8), pk8(8'd0, 1'b1, 1'b0, 1'b0));

    for (int i = 1; i <= 255; i++) begin
      @(posedge clk); #1;
      check("bounce8_up", i, pk8(count8, dir8, turn8, bnd_err8), pk8(8'(i), 1'b1, 1'b0, 1'b0));
    end
    @(posedge clk); #1;
    check("bounce8_top", 0, pk8(count8, dir8, turn8, bnd_err8), pk8(8'd254, 1'b0, 1'b1, 1'b0));
    for (int i = 253; i >= 0; i--) begin
      @(posedge clk); #1;
      check("bounce8_dn", i, pk8(count8, dir8, turn8, bnd_err8), pk8(8'(i), 1'b0, 1'b0, 1'b0));
    end
    @(posedge clk); #1;
    check("bounce8_bot", 0, pk8(count8, dir8, turn8, bnd_err8), pk8(8'd1, 1'b1, 1'b1, 1'b0));
    check("idle4", 0, pk4(count, dir, turn, bnd_err), pk4(4'd0, 1'b1, 1'b0, 1'b0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
